// File: rtl/hdmi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_pkg
// Description : Shared island phases, packet type codes and timing defaults
//               for the HDMI data-island packet scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package hdmi_pkg;

  typedef enum logic [2:0] {
    PH_IDLE        = 3'd0,
    PH_PREAMBLE    = 3'd1,
    PH_GUARD_LEAD  = 3'd2,
    PH_PACKET      = 3'd3,
    PH_GUARD_TRAIL = 3'd4
  } phase_t;

  localparam logic [7:0] PKT_NULL     = 8'h00;
  localparam logic [7:0] PKT_ACR      = 8'h01;
  localparam logic [7:0] PKT_AUDIO    = 8'h02;
  localparam logic [7:0] PKT_GCP      = 8'h03;
  localparam logic [7:0] PKT_VENDOR   = 8'h81;
  localparam logic [7:0] PKT_AVI      = 8'h82;
  localparam logic [7:0] PKT_SPD      = 8'h83;
  localparam logic [7:0] PKT_AUDIO_IF = 8'h84;

  localparam int DEF_PACKET_CYCLES     = 32;
  localparam int DEF_PREAMBLE_CYCLES   = 8;
  localparam int DEF_GUARD_CYCLES      = 2;
  localparam int DEF_MAX_PACKETS       = 18;
  localparam int DEF_AVI_PERIOD_FRAMES = 1;
  localparam int DEF_SPD_PERIOD_FRAMES = 60;

endpackage
`default_nettype wire

// File: rtl/hdmi_packet_priority.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_packet_priority
// Description : Fixed-priority picker over pending packet requests.
//               Bit order: 0=ACR, 1=audio, 2=GCP, 3=AVI, 4=SPD.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_packet_priority
  import hdmi_pkg::*;
(
  input  logic [4:0] pend,
  output logic [7:0] pkt_type,
  output logic [4:0] grant
);

  always_comb begin
    grant    = 5'b00000;
    pkt_type = PKT_NULL;
    if (pend[0]) begin
      grant    = 5'b00001;
      pkt_type = PKT_ACR;
    end else if (pend[1]) begin
      grant    = 5'b00010;
      pkt_type = PKT_AUDIO;
    end else if (pend[2]) begin
      grant    = 5'b00100;
      pkt_type = PKT_GCP;
    end else if (pend[3]) begin
      grant    = 5'b01000;
      pkt_type = PKT_AVI;
    end else if (pend[4]) begin
      grant    = 5'b10000;
      pkt_type = PKT_SPD;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hdmi_packet_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_packet_scheduler
// Description : Sequences HDMI data islands (preamble, guard bands, packet
//               slots) and chooses the auxiliary packet carried in each slot.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_packet_scheduler
  import hdmi_pkg::*;
#(
  parameter int PACKET_CYCLES     = DEF_PACKET_CYCLES,
  parameter int PREAMBLE_CYCLES   = DEF_PREAMBLE_CYCLES,
  parameter int GUARD_CYCLES      = DEF_GUARD_CYCLES,
  parameter int MAX_PACKETS       = DEF_MAX_PACKETS,
  parameter int AVI_PERIOD_FRAMES = DEF_AVI_PERIOD_FRAMES,
  parameter int SPD_PERIOD_FRAMES = DEF_SPD_PERIOD_FRAMES
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       FRAME_START,
  input  logic       AVMUTE_CHANGE,
  input  logic       ACR_TICK,
  input  logic       AUDIO_PENDING,
  input  logic       ISLAND_REQ,
  input  logic [4:0] ISLAND_SLOTS,
  output logic [7:0] PACKETTYPE,
  output logic       PACKET_START,
  output logic       AUDIO_POP,
  output logic [2:0] PHASE,
  output logic       ISLAND_DONE
);

  localparam int AVI_W = (AVI_PERIOD_FRAMES > 1) ? $clog2(AVI_PERIOD_FRAMES) : 1;
  localparam int SPD_W = (SPD_PERIOD_FRAMES > 1) ? $clog2(SPD_PERIOD_FRAMES) : 1;
  localparam logic [4:0] MAX_SLOTS = 5'(MAX_PACKETS);

  phase_t           phase_q, phase_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [4:0]       slots_left_q, slots_left_d;
  logic             acr_pend_q, acr_pend_d;
  logic             gcp_pend_q, gcp_pend_d;
  logic             avi_pend_q, avi_pend_d;
  logic             spd_pend_q, spd_pend_d;
  logic [AVI_W-1:0] avi_cnt_q, avi_cnt_d;
  logic [SPD_W-1:0] spd_cnt_q, spd_cnt_d;
  logic [7:0]       ptype_q, ptype_d;
  logic             pstart_q, pstart_d;
  logic             pop_q, pop_d;
  logic             done_q, done_d;

  logic [4:0] pend_vec;
  logic [4:0] grant;
  logic [7:0] pick_type;
  logic       any_pending;
  logic       pick_now;
  logic [4:0] clr;

  assign pend_vec    = {spd_pend_q, avi_pend_q, gcp_pend_q, AUDIO_PENDING, acr_pend_q};
  assign any_pending = |pend_vec;

  hdmi_packet_priority u_priority (
    .pend     (pend_vec),
    .pkt_type (pick_type),
    .grant    (grant)
  );

  always_comb begin
    phase_d      = phase_q;
    cnt_d        = cnt_q + 8'd1;
    slots_left_d = slots_left_q;
    ptype_d      = ptype_q;
    pstart_d     = 1'b0;
    pop_d        = 1'b0;
    pick_now     = 1'b0;
    clr          = 5'b00000;

    case (phase_q)
      PH_IDLE: begin
        cnt_d = 8'd0;
        if (ISLAND_REQ && (ISLAND_SLOTS != 5'd0) && any_pending) begin
          phase_d      = PH_PREAMBLE;
          slots_left_d = (ISLAND_SLOTS > MAX_SLOTS) ? MAX_SLOTS : ISLAND_SLOTS;
        end
      end
      PH_PREAMBLE: begin
        if (cnt_q == 8'(PREAMBLE_CYCLES - 1)) begin
          phase_d = PH_GUARD_LEAD;
          cnt_d   = 8'd0;
        end
      end
      PH_GUARD_LEAD: begin
        if (cnt_q == 8'(GUARD_CYCLES - 1)) begin
          phase_d  = PH_PACKET;
          cnt_d    = 8'd0;
          pick_now = 1'b1;
        end
      end
      PH_PACKET: begin
        if (cnt_q == 8'(PACKET_CYCLES - 1)) begin
          cnt_d        = 8'd0;
          slots_left_d = slots_left_q - 5'd1;
          if ((slots_left_q == 5'd1) || !any_pending) begin
            phase_d = PH_GUARD_TRAIL;
            ptype_d = PKT_NULL;
          end else begin
            pick_now = 1'b1;
          end
        end
      end
      PH_GUARD_TRAIL: begin
        if (cnt_q == 8'(GUARD_CYCLES - 1)) begin
          phase_d = PH_IDLE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        phase_d = PH_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // An empty pick still opens the slot, carrying a null packet.
    if (pick_now) begin
      ptype_d  = pick_type;
      pstart_d = 1'b1;
      pop_d    = grant[1];
      clr      = grant;
    end

    done_d = (phase_d == PH_GUARD_TRAIL) && (cnt_d == 8'(GUARD_CYCLES - 1));

    // A fresh request beats the clear of a packet starting this cycle.
    acr_pend_d = ACR_TICK | (acr_pend_q & ~clr[0]);
    gcp_pend_d = FRAME_START | AVMUTE_CHANGE | (gcp_pend_q & ~clr[2]);
    avi_pend_d = (FRAME_START && (avi_cnt_q == '0)) | (avi_pend_q & ~clr[3]);
    spd_pend_d = (FRAME_START && (spd_cnt_q == '0)) | (spd_pend_q & ~clr[4]);

    avi_cnt_d = avi_cnt_q;
    spd_cnt_d = spd_cnt_q;
    if (FRAME_START) begin
      avi_cnt_d = (avi_cnt_q == AVI_W'(AVI_PERIOD_FRAMES - 1)) ? '0 : avi_cnt_q + 1'b1;
      spd_cnt_d = (spd_cnt_q == SPD_W'(SPD_PERIOD_FRAMES - 1)) ? '0 : spd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_q      <= PH_IDLE;
      cnt_q        <= 8'd0;
      slots_left_q <= 5'd0;
      acr_pend_q   <= 1'b0;
      gcp_pend_q   <= 1'b0;
      avi_pend_q   <= 1'b0;
      spd_pend_q   <= 1'b0;
      avi_cnt_q    <= '0;
      spd_cnt_q    <= '0;
      ptype_q      <= PKT_NULL;
      pstart_q     <= 1'b0;
      pop_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      slots_left_q <= slots_left_d;
      acr_pend_q   <= acr_pend_d;
      gcp_pend_q   <= gcp_pend_d;
      avi_pend_q   <= avi_pend_d;
      spd_pend_q   <= spd_pend_d;
      avi_cnt_q    <= avi_cnt_d;
      spd_cnt_q    <= spd_cnt_d;
      ptype_q      <= ptype_d;
      pstart_q     <= pstart_d;
      pop_q        <= pop_d;
      done_q       <= done_d;
    end
  end

  assign PHASE        = phase_q;
  assign PACKETTYPE   = ptype_q;
  assign PACKET_START = pstart_q;
  assign AUDIO_POP    = pop_q;
  assign ISLAND_DONE  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_packet_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_packet_scheduler
// Description : Directed self-checking bench for hdmi_packet_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_packet_scheduler;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       FRAME_START = 1'b0;
  logic       AVMUTE_CHANGE = 1'b0;
  logic       ACR_TICK = 1'b0;
  logic       AUDIO_PENDING = 1'b0;
  logic       ISLAND_REQ = 1'b0;
  logic [4:0] ISLAND_SLOTS = 5'd0;
  logic [7:0] PACKETTYPE;
  logic       PACKET_START;
  logic       AUDIO_POP;
  logic [2:0] PHASE;
  logic       ISLAND_DONE;

  hdmi_packet_scheduler dut (
    .CLK           (CLK),
    .RST           (RST),
    .FRAME_START   (FRAME_START),
    .AVMUTE_CHANGE (AVMUTE_CHANGE),
    .ACR_TICK      (ACR_TICK),
    .AUDIO_PENDING (AUDIO_PENDING),
    .ISLAND_REQ    (ISLAND_REQ),
    .ISLAND_SLOTS  (ISLAND_SLOTS),
    .PACKETTYPE    (PACKETTYPE),
    .PACKET_START  (PACKET_START),
    .AUDIO_POP     (AUDIO_POP),
    .PHASE         (PHASE),
    .ISLAND_DONE   (ISLAND_DONE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Island observation results
  int         m_len, m_npk, m_pops, m_first, m_bad, m_pre, m_gl, m_gt, m_not_acr;
  logic [7:0] m_types [0:31];
  bit         tick_slots = 1'b0;
  bit         drop_audio = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    FRAME_START = 1'b0; AVMUTE_CHANGE = 1'b0; ACR_TICK = 1'b0;
    AUDIO_PENDING = 1'b0; ISLAND_REQ = 1'b0; ISLAND_SLOTS = 5'd0;
    step(); step();
    RST = 1'b0;
    step();
  endtask

  task automatic pulse_acr();
    ACR_TICK = 1'b1; step(); ACR_TICK = 1'b0;
  endtask

  task automatic pulse_frame();
    FRAME_START = 1'b1; step(); FRAME_START = 1'b0;
  endtask

  // Raise ISLAND_REQ in cycle 0, then observe cycles 1..budget until ISLAND_DONE.
  task automatic run_island(input logic [4:0] slots, input int budget);
    m_len = 0; m_npk = 0; m_pops = 0; m_first = 0; m_bad = 0;
    m_pre = 0; m_gl = 0; m_gt = 0; m_not_acr = 0;
    for (int i = 0; i < 32; i++) m_types[i] = 8'h00;
    ISLAND_REQ   = 1'b1;
    ISLAND_SLOTS = slots;
    for (int c = 1; c <= budget; c++) begin
      step();
      ISLAND_REQ = 1'b0;
      if (c == 1 && drop_audio) AUDIO_PENDING = 1'b0;
      ACR_TICK = tick_slots && (c >= 10) && (((c - 10) % 32) == 0) && (c <= 10 + 32 * 17);
      case (PHASE)
        3'd1: m_pre++;
        3'd2: m_gl++;
        3'd4: m_gt++;
        default: ;
      endcase
      if (PHASE != 3'd3 && PACKETTYPE != 8'h00) m_bad++;
      if (PACKET_START) begin
        if (m_npk == 0) m_first = c;
        if (m_npk < 32) m_types[m_npk] = PACKETTYPE;
        if (PACKETTYPE != 8'h01) m_not_acr++;
        m_npk++;
      end
      if (AUDIO_POP) begin
        m_pops++;
        if (!PACKET_START || PACKETTYPE != 8'h02) m_bad++;
      end
      if (ISLAND_DONE) begin
        m_len = c;
        break;
      end
    end
    ACR_TICK = 1'b0;
    step();
    check("idle_after_island", {29'd0, PHASE}, 32'd0);
  endtask

  // Request an island and confirm nothing happens for a while.
  task automatic expect_ignored(input string tag, input logic [4:0] slots);
    int nz;
    nz = 0;
    ISLAND_REQ   = 1'b1;
    ISLAND_SLOTS = slots;
    step();
    ISLAND_REQ = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (PHASE != 3'd0 || PACKET_START) nz++;
      step();
    end
    check(tag, nz, 0);
  endtask

  initial begin
    do_reset();
    check("reset_outputs", {19'd0, PHASE, PACKETTYPE, PACKET_START, AUDIO_POP, ISLAND_DONE}, 32'd0);

    // 1: no pending work, and zero slots with work pending
    expect_ignored("t1_no_pending", 5'd4);
    pulse_acr();
    expect_ignored("t1_zero_slots", 5'd0);

    // 2: single ACR packet, full island timing
    run_island(5'd4, 80);
    check("t2_len", m_len, 44);
    check("t2_first_start", m_first, 11);
    check("t2_npk", m_npk, 1);
    check("t2_type", m_types[0], 8'h01);
    check("t2_preamble", m_pre, 8);
    check("t2_guard_lead", m_gl, 2);
    check("t2_guard_trail", m_gt, 2);
    check("t2_type_outside", m_bad, 0);

    // Audio withdrawn during preamble: one null packet
    AUDIO_PENDING = 1'b1;
    drop_audio = 1'b1;
    run_island(5'd5, 80);
    drop_audio = 1'b0;
    check("null_npk", m_npk, 1);
    check("null_type", m_types[0], 8'h00);
    check("null_pops", m_pops, 0);
    check("null_len", m_len, 44);

    // 3: audio dominates GCP/AVI/SPD
    do_reset();
    pulse_frame();
    AUDIO_PENDING = 1'b1;
    run_island(5'd3, 200);
    AUDIO_PENDING = 1'b0;
    check("t3_npk", m_npk, 3);
    check("t3_types", {8'd0, m_types[0], m_types[1], m_types[2]}, 32'h00020202);
    check("t3_pops", m_pops, 3);
    check("t3_len", m_len, 108);
    check("t3_bad", m_bad, 0);

    // 4: leftover GCP/AVI/SPD drain in priority order
    pulse_frame();
    run_island(5'd18, 200);
    check("t4_npk", m_npk, 3);
    check("t4_types", {8'd0, m_types[0], m_types[1], m_types[2]}, 32'h00038283);
    check("t4_pops", m_pops, 0);
    check("t4_len", m_len, 108);

    // 5: slot cap and set-wins on concurrent tick/clear
    do_reset();
    pulse_acr();
    tick_slots = 1'b1;
    run_island(5'd25, 700);
    tick_slots = 1'b0;
    check("t5_npk", m_npk, 18);
    check("t5_all_acr", m_not_acr, 0);
    check("t5_len", m_len, 10 + 32 * 18 + 2);
    run_island(5'd1, 80);
    check("t5_acr_kept_npk", m_npk, 1);
    check("t5_acr_kept_type", m_types[0], 8'h01);

    // 6: reset in the middle of a packet slot
    do_reset();
    pulse_acr();
    ISLAND_REQ   = 1'b1;
    ISLAND_SLOTS = 5'd2;
    for (int c = 1; c <= 31; c++) begin
      step();
      ISLAND_REQ = 1'b0;
    end
    check("t6_mid_phase", {29'd0, PHASE}, 32'd3);
    check("t6_mid_type", {24'd0, PACKETTYPE}, 32'h01);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("t6_rst_outputs", {19'd0, PHASE, PACKETTYPE, PACKET_START, AUDIO_POP, ISLAND_DONE}, 32'd0);
    expect_ignored("t6_flags_cleared", 5'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hdmi_packet_scheduler.md
Name: hdmi_packet_scheduler

Overview:
Sequences HDMI data islands during blanking and picks which auxiliary packet type goes in each 32-cycle packet slot. It tracks pending requests for ACR, audio sample, GCP, AVI and SPD, and arbitrates them by fixed priority. PACKETTYPE drives the packet wizard, and PHASE drives the TMDS channel muxing (preamble, guard band, packet).

Parameters:
PACKET_CYCLES, 32, pixel clocks per packet slot
PREAMBLE_CYCLES, 8, preamble length before the leading guard band
GUARD_CYCLES, 2, length of the leading and the trailing guard band
MAX_PACKETS, 18, hard cap on packets per island
AVI_PERIOD_FRAMES, 1, AVI InfoFrame is requested every N frames
SPD_PERIOD_FRAMES, 60, SPD InfoFrame is requested every N frames

Ports:
CLK  in  1  pixel clock
RST  in  1  synchronous, active-high reset
FRAME_START  in  1  one-cycle pulse at start of vertical blank
AVMUTE_CHANGE  in  1  one-cycle pulse; requests a GCP
ACR_TICK  in  1  one-cycle pulse; requests an ACR packet
AUDIO_PENDING  in  1  audio sample FIFO is non-empty
ISLAND_REQ  in  1  one-cycle pulse; a data-island window opens
ISLAND_SLOTS  in  5  number of packet slots that fit in the window (0..31)
PACKETTYPE  out  8  type code of the current packet, held for the whole slot
PACKET_START  out  1  pulse on the first cycle of each packet slot
AUDIO_POP  out  1  pulse coincident with PACKET_START of an audio sample packet
PHASE  out  3  IDLE / PREAMBLE / GUARD_LEAD / PACKET / GUARD_TRAIL
ISLAND_DONE  out  1  pulse on the last GUARD_TRAIL cycle

Behaviour:
- Reset: all outputs are 0, PHASE=IDLE, all pending flags clear, frame counters 0. Reset mid-island aborts the island immediately.
- Pending flags are set by their pulses and cleared when their packet starts. Set wins if set and clear land in the same cycle.
  - acr_pend: set by ACR_TICK.
  - gcp_pend: set by FRAME_START or AVMUTE_CHANGE.
  - avi_pend / spd_pend: set on FRAME_START when the respective frame counter equals 0. Each counter counts 0..PERIOD-1 and wraps.
- Audio is not a flag; it is sampled live from AUDIO_PENDING.
- Priority: ACR(0x01) > audio(0x02) > GCP(0x03) > AVI(0x82) > SPD(0x83).
- "any_pending" means any flag is set or AUDIO_PENDING is high.
- Island opening: ISLAND_REQ is accepted only when PHASE=IDLE, ISLAND_SLOTS≠0 and any_pending. Otherwise it is ignored; no island, no nulls.
- slots_left is latched as min(ISLAND_SLOTS, MAX_PACKETS).
- FSM, with ISLAND_REQ accepted in cycle 0:
  - IDLE → PREAMBLE, cycles 1..8.
  - GUARD_LEAD, cycles 9..10.
  - PACKET, first slot cycles 11..42.
  - GUARD_TRAIL, 2 cycles.
  - IDLE.
- Slot boundary: on the last cycle of GUARD_LEAD or of a PACKET slot, the arbiter picks the highest-priority pending type.
  - The choice is registered: PACKETTYPE updates and PACKET_START pulses on the next cycle.
  - PACKETTYPE is held for PACKET_CYCLES cycles.
  - The winner's flag clears in the PACKET_START cycle.
- Continuation, checked on the last cycle of a slot:
  - After decrementing slots_left, if slots_left==0 or !any_pending → GUARD_TRAIL.
  - Otherwise another PACKET slot follows.
  - The island always carries at least 1 packet. If pending is dropped during preamble, the first slot sends null 0x00.
- Requests arriving mid-island (e.g. FRAME_START during PACKET) are eligible at the next slot boundary.
- ISLAND_REQ while not IDLE is ignored and not queued.
- PACKETTYPE returns to 0x00 when PHASE leaves PACKET.

Decomposition:
- Package hdmi_pkg holds:
  - phase_t enum (IDLE=0, PREAMBLE=1, GUARD_LEAD=2, PACKET=3, GUARD_TRAIL=4).
  - Packet type localparams PKT_NULL/ACR/AUDIO/GCP/VENDOR/AVI/SPD/AUDIO_IF.
  - Timing defaults.
- Sub-module hdmi_packet_priority: combinational fixed-priority picker; inputs are the pending vector, output is the 8-bit type plus one-hot grant.

Test Plan:
1. After reset, ISLAND_REQ with no pending → PHASE stays IDLE, no PACKET_START.
2. ACR_TICK then ISLAND_REQ with SLOTS=4 → PREAMBLE 8 cycles, GUARD_LEAD 2 cycles, then PACKETTYPE=0x01 for 32 cycles, GUARD_TRAIL 2 cycles, ISLAND_DONE; island length 44 cycles.
3. FRAME_START (AVI period 1, frame 0), AUDIO_PENDING=1 held, SLOTS=3 → packet order 0x02,0x02,0x02 with AUDIO_POP ×3; GCP/AVI/SPD remain pending.
4. Same as 3 with AUDIO_PENDING=0 and SLOTS=18 → packet order 0x03,0x82,0x83, then GUARD_TRAIL after slot 3.
5. SLOTS=25 with ACR_TICK pulsed every slot → exactly 18 packets, then GUARD_TRAIL; a concurrent ACR_TICK and clear leaves acr_pend=1.
6. RST asserted at cycle 20 of a packet slot → next cycle PHASE=IDLE, PACKETTYPE=0, all flags clear; a following ISLAND_REQ is ignored.
